// File: rtl/fir_chain_ctrl.sv
// rtl/fir_chain_ctrl.sv - sequencer and coefficient controller for a systolic FIR slice chain
//
// Holds the per-tap coefficient bank, gates samples into the head slice,
// tracks the fixed chain latency and qualifies the tail accumulator as a
// result stream. Flushes the chain on stop and counts input underruns.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_valid/ready/addr/data  coefficient write (accepted in IDLE only)
//   start, stop           single-cycle control pulses
//   s_valid/s_ready/s_data     4-bit input sample stream
//   coef_bus              tap k coefficient at bits [8k+7:8k]
//   chain_x               registered sample to head slice
//   chain_acc             tail slice accumulator output
//   y_valid, y_data       qualified registered result
//   busy                  high in RUN or FLUSH
//   underrun_cnt          saturating count of empty RUN slots
module fir_chain_ctrl #(
  parameter int NTAPS     = 4,
  parameter int CHAIN_LAT = 2 * NTAPS + 2,
  parameter int AW        = $clog2(NTAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [7:0]         cfg_data,
  input  logic               start,
  input  logic               stop,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [3:0]         s_data,
  output logic [NTAPS*8-1:0] coef_bus,
  output logic [3:0]         chain_x,
  input  logic [11:0]        chain_acc,
  output logic               y_valid,
  output logic [11:0]        y_data,
  output logic               busy,
  output logic [15:0]        underrun_cnt
);

  localparam int CW = $clog2(CHAIN_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       coef [NTAPS];
  logic [CHAIN_LAT:0] mark_sr;
  logic [CW-1:0]    flush_cnt;
  logic             slot;

  // The stop cycle itself is not a sample slot.
  assign slot      = (state == RUN) && !stop;

  assign cfg_ready = (state == IDLE);
  assign s_ready   = (state == RUN);
  assign busy      = (state != IDLE);

  genvar g;
  generate
    for (g = 0; g < NTAPS; g++) begin : g_coef_bus
      assign coef_bus[8*g +: 8] = coef[g];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      chain_x      <= '0;
      y_valid      <= 1'b0;
      y_data       <= '0;
      underrun_cnt <= '0;
      mark_sr      <= '0;
      flush_cnt    <= '0;
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else begin
      // Result path: free-running, qualified by the delayed slot marker.
      y_data  <= chain_acc;
      y_valid <= mark_sr[CHAIN_LAT];
      mark_sr <= {mark_sr[CHAIN_LAT-1:0], slot};

      // Empty slots and non-RUN cycles feed zeros so the chain drains clean.
      chain_x <= (slot && s_valid) ? s_data : 4'd0;

      if (slot && !s_valid && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;

      // Addresses beyond the bank match no tap and are silently dropped.
      if (state == IDLE && cfg_valid) begin
        for (int k = 0; k < NTAPS; k++)
          if (cfg_addr == AW'(k)) coef[k] <= cfg_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            underrun_cnt <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          // CHAIN_LAT+1 cycles: the last marker leaves as FLUSH ends.
          if (flush_cnt == CW'(CHAIN_LAT)) state <= IDLE;
          else                             flush_cnt <= flush_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
